fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 79 +++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the instruction-memory PC through an
// IDLE/RUN/HALTED program lifecycle and counts retired instructions.
module fetch_sequencer #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [PC_W-1:0]  StartAddr,
   input  logic             Halt,
   input  logic             JumpEn,
   input  logic             BranchEn,
   input  logic             Zero,
   input  logic [PC_W-1:0]  Target,
   input  logic             Stall,
   output logic [PC_W-1:0]  PC,
   output logic             FetchValid,
   output logic             Done,
   output logic [CNT_W-1:0] InstrCount
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALT
   } state_t;

   state_t           state_q;
   logic [PC_W-1:0]  pc_q;
   logic [CNT_W-1:0] cnt_q;
   logic             done_q;
   logic             take_tgt;

   // Jump+branch together takes Target whatever Zero says.
   assign take_tgt = JumpEn | (BranchEn & Zero);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else if (!Stall) begin
         unique case (state_q)
            S_IDLE, S_HALT: begin
               if (Start) begin
                  state_q <= S_RUN;
                  pc_q    <= StartAddr;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
               end
            end
            S_RUN: begin
               if (cnt_q != '1)
                  cnt_q <= cnt_q + CNT_W'(1);
               if (Halt) begin
                  state_q <= S_HALT;
                  done_q  <= 1'b1;
               end else if (take_tgt) begin
                  pc_q <= Target;
               end else begin
                  pc_q <= pc_q + PC_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign PC         = pc_q;
   assign InstrCount = cnt_q;
   assign Done       = done_q;
   assign FetchValid = (state_q == S_RUN);

endmodule
